// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg                                                            |
// | Shared core constants and the fetch-stage state encoding.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pc_reg                                                         |
// | Fetch PC register with +4 adder and redirect/alignment mux.          |
// | Option: IFETCH_MISALIGN_CHECK_EN rejects unaligned redirect targets. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_pc_reg #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_advance,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_target,
    output logic [XLEN-1:0] o_pc_f,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_redirect_taken,
    output logic            o_misaligned
);

    logic [XLEN-1:0] r_pc_f;
    logic [XLEN-1:0] w_target;
    logic            w_taken;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign w_taken      = i_redirect && (i_target[1:0] == 2'b00);
    assign o_misaligned = i_redirect && (i_target[1:0] != 2'b00);
    assign w_target     = i_target;
`else
    assign w_taken      = i_redirect;
    assign o_misaligned = 1'b0;
    assign w_target     = i_target & ~{{(XLEN-2){1'b0}}, 2'b11};
`endif

    assign o_pc_plus4       = r_pc_f + XLEN'(4);
    assign o_pc_f           = r_pc_f;
    assign o_redirect_taken = w_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_f <= RESET_PC;
        end else if (w_taken) begin
            r_pc_f <= w_target;
        end else if (i_advance) begin
            r_pc_f <= o_pc_plus4;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch                                                    |
// | Fetch stage: single-outstanding imem requests, decode handshake,     |
// | redirect with stale-response kill.                                   |
// | Option: IFETCH_MISALIGN_CHECK_EN (see fetch_pc_reg).                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
    parameter int          XLEN     = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            Imem_Req,
    output logic [XLEN-1:0] Imem_Addr,
    input  logic            Imem_Gnt,
    input  logic            Imem_Rvalid,
    input  logic [31:0]     Imem_Rdata,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic [31:0]     Instr,
    output logic            Instr_Valid,
    input  logic            Instr_Ready,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            Misaligned_Err
);

    import riscv_pkg::*;

    localparam logic [XLEN-1:0] C_RESET_PC = XLEN'(RESET_PC);

    fetch_state_t    r_state;
    logic            r_kill;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_misaligned;

    logic [XLEN-1:0] w_pc_f;
    logic [XLEN-1:0] w_pc_f_plus4;
    logic            w_redirect;
    logic            w_misaligned;
    logic            w_advance;

    // pc_f moves on only when a live response is accepted
    assign w_advance = (r_state == S_WAIT) && Imem_Rvalid && !r_kill;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (C_RESET_PC)
    ) u_fetch_pc_reg (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_advance        (w_advance),
        .i_redirect       (PCSrc),
        .i_target         (PCTarget),
        .o_pc_f           (w_pc_f),
        .o_pc_plus4       (w_pc_f_plus4),
        .o_redirect_taken (w_redirect),
        .o_misaligned     (w_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_kill       <= 1'b0;
            r_instr      <= RV_NOP;
            r_pc         <= C_RESET_PC;
            r_pc_plus4   <= C_RESET_PC + XLEN'(4);
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_misaligned;
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    // a grant in the redirect cycle still issues the old address
                    if (Imem_Gnt) begin
                        r_state <= S_WAIT;
                        r_kill  <= w_redirect;
                    end
                end
                S_WAIT: begin
                    if (Imem_Rvalid) begin
                        r_kill <= 1'b0;
                        if (r_kill || w_redirect) begin
                            r_state <= S_REQ;
                        end else begin
                            r_instr    <= Imem_Rdata;
                            r_pc       <= w_pc_f;
                            r_pc_plus4 <= w_pc_f_plus4;
                            r_state    <= S_VALID;
                        end
                    end else if (w_redirect) begin
                        r_kill <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (Instr_Ready || w_redirect) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Imem_Req       = (r_state == S_REQ);
    assign Imem_Addr      = w_pc_f;
    assign Instr_Valid    = (r_state == S_VALID);
    assign Instr          = r_instr;
    assign PC             = r_pc;
    assign PCPlus4        = r_pc_plus4;
    assign Misaligned_Err = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instruction_fetch                                                 |
// | Directed bench for instruction_fetch with a small imem responder.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Gnt;
    logic        Imem_Rvalid;
    logic [31:0] Imem_Rdata;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Misaligned_Err;

    int total = 0;
    int bad   = 0;

    int          gnt_delay = 0;
    int          rsp_delay = 0;
    int          gnt_left  = 0;
    bit          in_req    = 1'b0;
    bit          pend      = 1'b0;
    int          pend_wait = 0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] grant_log[$];
    int          n0;

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Imem_Req       (Imem_Req),
        .Imem_Addr      (Imem_Addr),
        .Imem_Gnt       (Imem_Gnt),
        .Imem_Rvalid    (Imem_Rvalid),
        .Imem_Rdata     (Imem_Rdata),
        .PCSrc          (PCSrc),
        .PCTarget       (PCTarget),
        .Instr          (Instr),
        .Instr_Valid    (Instr_Valid),
        .Instr_Ready    (Instr_Ready),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
        .Misaligned_Err (Misaligned_Err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h4) ? 32'hFFFF_F813 : (32'h1000_0000 | a);
    endfunction

    // Memory model: grants after gnt_delay request cycles, responds rsp_delay cycles after grant.
    initial begin
        Imem_Gnt    = 1'b0;
        Imem_Rvalid = 1'b0;
        Imem_Rdata  = 32'h0;
        forever begin
            @(negedge clk);
            Imem_Rvalid = 1'b0;
            if (pend) begin
                if (pend_wait == 0) begin
                    Imem_Rvalid = 1'b1;
                    Imem_Rdata  = mem_word(pend_addr);
                    pend        = 1'b0;
                end else begin
                    pend_wait--;
                end
            end
            Imem_Gnt = 1'b0;
            if (Imem_Req) begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    gnt_left = gnt_delay;
                end
                if (gnt_left > 0) begin
                    gnt_left--;
                end else begin
                    Imem_Gnt  = 1'b1;
                    in_req    = 1'b0;
                    pend      = 1'b1;
                    pend_wait = rsp_delay;
                    pend_addr = Imem_Addr;
                    grant_log.push_back(Imem_Addr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && !Instr_Valid; i++) tick();
        chk("valid_seen", Instr_Valid, 1);
    endtask

    task automatic wait_req(input int max);
        for (int i = 0; i < max && !Imem_Req; i++) tick();
        chk("req_seen", Imem_Req, 1);
    endtask

    task automatic pulse_redirect(input logic [31:0] t);
        PCSrc    = 1'b1;
        PCTarget = t;
        tick();
        PCSrc    = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        Instr_Ready = 1'b1;
        PCSrc       = 1'b0;
        PCTarget    = 32'h0;

        tick();
        tick();
        chk("rst_valid", Instr_Valid, 0);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_req", Imem_Req, 0);
        chk("rst_addr", Imem_Addr, 32'h0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_pcp4", PCPlus4, 32'h4);
        chk("rst_mis", Misaligned_Err, 0);

        // Zero-wait fetches of 0x0 and 0x4
        rst_n = 1'b1;
        tick();
        chk("req0", Imem_Req, 1);
        chk("addr0", Imem_Addr, 32'h0);
        tick();
        chk("wait0_req", Imem_Req, 0);
        tick();
        chk("v0_valid", Instr_Valid, 1);
        chk("v0_instr", Instr, 32'h1000_0000);
        chk("v0_pc", PC, 32'h0);
        chk("v0_pcp4", PCPlus4, 32'h4);
        tick();
        chk("req4", Imem_Req, 1);
        chk("addr4", Imem_Addr, 32'h4);
        chk("req4_valid", Instr_Valid, 0);
        Instr_Ready = 1'b0;
        tick();
        tick();
        chk("v4_instr", Instr, 32'hFFFF_F813);
        chk("v4_pc", PC, 32'h4);
        chk("v4_pcp4", PCPlus4, 32'h8);

        // Decode stalled: everything holds, no new request
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", Instr_Valid, 1);
            chk("stall_req", Imem_Req, 0);
            chk("stall_instr", Instr, 32'hFFFF_F813);
            chk("stall_pc", PC, 32'h4);
            chk("stall_pcp4", PCPlus4, 32'h8);
        end

        // Redirect to 0x100 while waiting on 0x8
        rsp_delay   = 2;
        Instr_Ready = 1'b1;
        tick();
        chk("req8", Imem_Req, 1);
        chk("addr8", Imem_Addr, 32'h8);
        tick();
        chk("wait8_req", Imem_Req, 0);
        pulse_redirect(32'h100);
        chk("kill_wait_req", Imem_Req, 0);
        rsp_delay = 0;
        wait_req(10);
        chk("redir_addr", Imem_Addr, 32'h100);
        wait_valid(10);
        chk("redir_instr", Instr, 32'h1000_0100);
        chk("redir_pc", PC, 32'h100);
        chk("redir_pcp4", PCPlus4, 32'h104);
        chk("grant_cnt", grant_log.size(), 4);
        chk("grant_0", grant_log[0], 32'h0);
        chk("grant_1", grant_log[1], 32'h4);
        chk("grant_2", grant_log[2], 32'h8);
        chk("grant_3", grant_log[3], 32'h100);

        // Grant withheld, redirect to 0x40 before the grant
        gnt_delay = 3;
        n0 = grant_log.size();
        tick();
        chk("req104", Imem_Req, 1);
        chk("addr104", Imem_Addr, 32'h104);
        tick();
        chk("hold_addr", Imem_Addr, 32'h104);
        pulse_redirect(32'h40);
        chk("pregnt_req", Imem_Req, 1);
        chk("pregnt_addr", Imem_Addr, 32'h40);
        gnt_delay = 0;
        wait_valid(15);
        chk("g40_instr", Instr, 32'h1000_0040);
        chk("g40_pc", PC, 32'h40);
        chk("g40_cnt", grant_log.size() - n0, 1);
        chk("g40_addr", grant_log[n0], 32'h40);

        // Redirect from the valid state to the top word, then wrap
        pulse_redirect(32'hFFFF_FFFC);
        chk("vredir_valid", Instr_Valid, 0);
        chk("vredir_req", Imem_Req, 1);
        chk("vredir_addr", Imem_Addr, 32'hFFFF_FFFC);
        wait_valid(10);
        chk("top_instr", Instr, 32'hFFFF_FFFC);
        chk("top_pc", PC, 32'hFFFF_FFFC);
        chk("top_pcp4", PCPlus4, 32'h0);
        wait_req(10);
        chk("wrap_addr", Imem_Addr, 32'h0);
        wait_valid(10);
        chk("wrap_instr", Instr, 32'h1000_0000);
        chk("wrap_pc", PC, 32'h0);

        // Misaligned redirect target
        pulse_redirect(32'h102);
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk("mis_pulse", Misaligned_Err, 1);
        chk("mis_addr", Imem_Addr, 32'h4);
        tick();
        chk("mis_clear", Misaligned_Err, 0);
        wait_valid(10);
        chk("mis_instr", Instr, 32'hFFFF_F813);
        chk("mis_pc", PC, 32'h4);
`else
        chk("mis_pulse", Misaligned_Err, 0);
        chk("mis_addr", Imem_Addr, 32'h100);
        tick();
        chk("mis_clear", Misaligned_Err, 0);
        wait_valid(10);
        chk("mis_instr", Instr, 32'h1000_0100);
        chk("mis_pc", PC, 32'h100);
`endif

        // Reset while a response is in flight
        rsp_delay = 1;
        tick();
        chk("prerst_req", Imem_Req, 1);
        tick();
        chk("prerst_wait", Imem_Req, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", Instr_Valid, 0);
        chk("arst_req", Imem_Req, 0);
        chk("arst_instr", Instr, 32'h0000_0013);
        chk("arst_pc", PC, 32'h0);
        chk("arst_pcp4", PCPlus4, 32'h4);
        chk("arst_addr", Imem_Addr, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", Instr_Valid, 0);
        chk("post_rst_req", Imem_Req, 1);
        chk("post_rst_addr", Imem_Addr, 32'h0);
        wait_valid(20);
        chk("post_rst_instr", Instr, 32'h1000_0000);
        chk("post_rst_pc", PC, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
